switch_mcu_ahb_sram_slave: RTL and testbench
============================================

SWITCH_MCU_AHB_SRAM_SLAVE -- requirements
Module: switch_mcu_ahb_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15, wait states inserted before each OKAY data phase completes.
REQ-003 in_clk  input  1  sole clock, all state on rising edge.
REQ-004 in_rst  input  1  reset, asynchronous, active-high.
REQ-005 in_hsel  input  1  slave select, address phase.
REQ-006 in_haddr  input  32  byte address, address phase.
REQ-007 in_hwrite  input  1  1 = write, 0 = read.
REQ-008 in_hsize  input  4  0 byte, 1 halfword, 2 word; other values illegal.
REQ-009 in_hburst  input  3  burst type, accepted and ignored; each beat is handled independently.
REQ-010 in_htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-011 in_hwdata  input  32  write data, data phase.
REQ-012 out_hready  output  1  data phase complete / slave ready.
REQ-013 out_hresp  output  1  0 OKAY, 1 ERROR.
REQ-014 out_hrdata  output  32  read data, full word, little-endian lanes.

Function
REQ-015 A transfer SHALL be accepted when in_hsel=1, out_hready=1 and in_htrans[1]=1; address, hwrite, hsize and error status are registered at that edge.
REQ-016 IDLE/BUSY or in_hsel=0 with out_hready=1 SHALL produce a zero-wait OKAY response and no memory access.
REQ-017 Error status SHALL be set if in_haddr[31:ADDR_W+2]!=0, in_hsize>2, hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.
REQ-018 State machine: IDLE, WAIT, ERR1, ERR2; accepted OKAY transfer -> WAIT if WAIT_CYCLES>0, else completes next cycle from IDLE; accepted error transfer -> ERR1.
REQ-019 WAIT: out_hready=0, out_hresp=0 for exactly WAIT_CYCLES cycles (4-bit down-counter), then one cycle out_hready=1, out_hresp=0.
REQ-020 ERR1: out_hready=0, out_hresp=1; ERR2: out_hready=1, out_hresp=1; memory untouched, out_hrdata unchanged.
REQ-021 Read: out_hrdata SHALL equal mem[addr[ADDR_W+1:2]] in the data-phase cycle where out_hready=1; it holds that value until the next read completes.
REQ-022 Write: in_hwdata SHALL be sampled in the data-phase cycle where out_hready=1; byte enables byte=1<<addr[1:0], half=3<<addr[1:0], word=4'hF; lanes not enabled unchanged.
REQ-023 Pipelining: a new address phase SHALL be accepted in the same cycle a previous data phase completes; back-to-back transfers with WAIT_CYCLES=0 SHALL sustain one per cycle.
REQ-024 Read immediately following a write to the same word SHALL return the newly written data.
REQ-025 in_hsel, in_htrans changes during a stalled data phase SHALL be ignored until out_hready=1.
REQ-026 Memory array SHALL not be reset; contents SHALL be preloadable by simulation file.

Reset
REQ-027 On in_rst=1: state IDLE, wait counter 0, out_hready=1, out_hresp=0, out_hrdata=32'h0.
REQ-028 Reset asserted mid-WAIT SHALL abort the transfer with no memory write.

Verification
REQ-029 WAIT_CYCLES=0: write word 32'hDEADBEEF to 0x10, read 0x10 next beat -> hready never low, hrdata=32'hDEADBEEF.
REQ-030 WAIT_CYCLES=2: read 0x0 -> hready low 2 cycles, high on 3rd with hresp=0 and correct data.
REQ-031 Byte write 8'hA5 to 0x13 over word 32'h11223344 at 0x10 -> read returns 32'hA5223344.
REQ-032 Word access to 0x12 and access to 0x0000_1000 (ADDR_W=10) -> each gives ERR1 (hready=0,hresp=1) then ERR2 (hready=1,hresp=1), memory unchanged.
REQ-033 htrans=IDLE and BUSY with hsel=1 -> hready=1, hresp=0 every cycle, no write.
REQ-034 Assert in_rst during WAIT of a write to 0x20 -> outputs return to reset values asynchronously; later read of 0x20 shows old data.

Source files
------------

// File: rtl/switch_mcu_ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte-lane writes,
// configurable wait states and two-cycle ERROR response for illegal accesses.
module switch_mcu_ahb_sram_slave #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_hsel,
    input  logic [31:0] in_haddr,
    input  logic        in_hwrite,
    input  logic [3:0]  in_hsize,
    input  logic [2:0]  in_hburst,
    input  logic [1:0]  in_htrans,
    input  logic [31:0] in_hwdata,
    output logic        out_hready,
    output logic        out_hresp,
    output logic [31:0] out_hrdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                pend_q;
    logic                write_q;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                req_err;
    logic [3:0]          req_be;
    logic [ADDR_W-1:0]   req_idx;
    logic                complete;
    logic                wr_en;
    logic                rd_load;
    logic [ADDR_W-1:0]   rd_idx;
    logic [31:0]         rd_word;
    logic                unused_bits;

    assign unused_bits = ^{in_hburst, in_htrans[0]};

    // Address-phase decode: lane enables and legality of the request
    always_comb begin
        req_idx = in_haddr[ADDR_W+1:2];
        req_be  = 4'hF;
        case (in_hsize)
            4'd0:    req_be = 4'b0001 << in_haddr[1:0];
            4'd1:    req_be = 4'b0011 << in_haddr[1:0];
            default: req_be = 4'hF;
        endcase
        req_err = ((in_haddr >> (ADDR_W + 2)) != 32'd0)
               || (in_hsize > 4'd2)
               || ((in_hsize == 4'd1) && in_haddr[0])
               || ((in_hsize == 4'd2) && (in_haddr[1:0] != 2'b00));
    end

    assign accept   = in_hsel && out_hready && in_htrans[1];
    assign complete = (state == ST_IDLE) && pend_q;
    assign wr_en    = complete && write_q;

    // Read data is captured on the edge that opens the completing cycle
    assign rd_load = ((WAIT_CYCLES == 0) && accept && !req_err && !in_hwrite)
                  || ((state == ST_WAIT) && (cnt == 4'd1) && !write_q);
    assign rd_idx  = (state == ST_WAIT) ? idx_q : req_idx;

    // Forward lanes of a write retiring on the same edge as the read capture
    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (idx_q == rd_idx) && be_q[b]) begin
                rd_word[8*b +: 8] = in_hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_hready = 1'b1;
        out_hresp  = 1'b0;
        case (state)
            ST_WAIT: out_hready = 1'b0;
            ST_ERR1: begin
                out_hready = 1'b0;
                out_hresp  = 1'b1;
            end
            ST_ERR2: out_hresp = 1'b1;
            default: ;
        endcase
    end

    // Data-phase bookkeeping, wait counter and read-data holding register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt        <= 4'd0;
            pend_q     <= 1'b0;
            write_q    <= 1'b0;
            be_q       <= 4'd0;
            idx_q      <= '0;
            out_hrdata <= 32'h0;
        end else begin
            if (accept) begin
                pend_q  <= !req_err;
                write_q <= in_hwrite;
                be_q    <= req_be;
                idx_q   <= req_idx;
            end else if (complete) begin
                pend_q <= 1'b0;
            end
            if (accept && !req_err) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_load) begin
                out_hrdata <= rd_word;
            end
        end
    end

    // Memory is deliberately not reset
    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= in_hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_mcu_ahb_sram_slave.sv
// Directed bench: instance 0 runs with no wait states, instance 1 with two.
module tb_switch_mcu_ahb_sram_slave;

    logic        clk;
    logic        rst;
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [3:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [31:0] hrdata [2];

    int checks;
    int failures;

    switch_mcu_ahb_sram_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .in_clk(clk), .in_rst(rst), .in_hsel(hsel[0]), .in_haddr(haddr[0]),
        .in_hwrite(hwrite[0]), .in_hsize(hsize[0]), .in_hburst(hburst[0]),
        .in_htrans(htrans[0]), .in_hwdata(hwdata[0]), .out_hready(hready[0]),
        .out_hresp(hresp[0]), .out_hrdata(hrdata[0])
    );

    switch_mcu_ahb_sram_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_hsel(hsel[1]), .in_haddr(haddr[1]),
        .in_hwrite(hwrite[1]), .in_hsize(hsize[1]), .in_hburst(hburst[1]),
        .in_htrans(htrans[1]), .in_hwdata(hwdata[1]), .out_hready(hready[1]),
        .out_hresp(hresp[1]), .out_hrdata(hrdata[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'd0;
        hwrite[d] = 1'b0;
        haddr[d]  = 32'h0;
        hsize[d]  = 4'd2;
        hburst[d] = 3'd0;
    endtask

    // Single non-pipelined transfer; returns wait count and responses seen
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [3:0] sz, input logic [31:0] wd,
                        output int waits, output logic r_first,
                        output logic r_last, output logic [31:0] rd);
        @(negedge clk);
        hsel[d]   = 1'b1;
        htrans[d] = 2'd2;
        hwrite[d] = wr;
        haddr[d]  = a;
        hsize[d]  = sz;
        hburst[d] = 3'd1;
        @(negedge clk);
        idle_bus(d);
        hwdata[d] = wd;
        waits     = 0;
        r_first   = hresp[d];
        while (!hready[d] && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        r_last = hresp[d];
        rd     = hrdata[d];
    endtask

    task automatic wr_ok(input int d, input logic [31:0] a, input logic [3:0] sz,
                         input logic [31:0] wd, input int exp_waits, input string tag);
        int w; logic rf; logic rl; logic [31:0] rd;
        xfer(d, 1'b1, a, sz, wd, w, rf, rl, rd);
        chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
        chk({tag, "_resp"}, {31'd0, rl}, 32'd0);
    endtask

    task automatic rd_ok(input int d, input logic [31:0] a, input logic [31:0] exp,
                         input int exp_waits, input string tag);
        int w; logic rf; logic rl; logic [31:0] rd;
        xfer(d, 1'b0, a, 4'd2, 32'h0, w, rf, rl, rd);
        chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
        chk({tag, "_resp0"}, {31'd0, rf}, 32'd0);
        chk({tag, "_resp"}, {31'd0, rl}, 32'd0);
        chk({tag, "_data"}, rd, exp);
    endtask

    task automatic err_xfer(input int d, input logic [31:0] a, input logic [3:0] sz,
                            input string tag);
        int w; logic rf; logic rl; logic [31:0] rd;
        xfer(d, 1'b1, a, sz, 32'hFFFF_FFFF, w, rf, rl, rd);
        chk({tag, "_err1_cycles"}, 32'(w), 32'd1);
        chk({tag, "_err1_resp"}, {31'd0, rf}, 32'd1);
        chk({tag, "_err2_resp"}, {31'd0, rl}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle_bus(d);
            hwdata[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_hready", {31'd0, hready[d]}, 32'd1);
            chk("reset_hresp", {31'd0, hresp[d]}, 32'd0);
            chk("reset_hrdata", hrdata[d], 32'h0);
        end
        rst = 1'b0;

        // Zero-wait write then read of the same word on consecutive beats
        @(negedge clk);
        hsel[0] = 1'b1; htrans[0] = 2'd2; hwrite[0] = 1'b1;
        haddr[0] = 32'h10; hsize[0] = 4'd2;
        @(negedge clk);
        chk("pipe_wr_hready", {31'd0, hready[0]}, 32'd1);
        hwdata[0] = 32'hDEAD_BEEF;
        hwrite[0] = 1'b0;
        @(negedge clk);
        chk("pipe_rd_hready", {31'd0, hready[0]}, 32'd1);
        chk("pipe_rd_hresp", {31'd0, hresp[0]}, 32'd0);
        chk("pipe_rd_data", hrdata[0], 32'hDEAD_BEEF);
        idle_bus(0);
        rd_ok(0, 32'h10, 32'hDEAD_BEEF, 0, "w0_reread");

        // Two wait states
        wr_ok(1, 32'h0, 4'd2, 32'hCAFE_F00D, 2, "w2_wr0");
        rd_ok(1, 32'h0, 32'hCAFE_F00D, 2, "w2_rd0");

        // Byte and halfword lane merging
        wr_ok(1, 32'h10, 4'd2, 32'h1122_3344, 2, "w2_wr10");
        wr_ok(1, 32'h13, 4'd0, 32'hA5FF_FFFF, 2, "w2_byte13");
        rd_ok(1, 32'h10, 32'hA522_3344, 2, "w2_rd10");
        wr_ok(1, 32'h14, 4'd2, 32'h5566_7788, 2, "w2_wr14");
        wr_ok(1, 32'h16, 4'd1, 32'hBEEF_FFFF, 2, "w2_half16");
        rd_ok(1, 32'h14, 32'hBEEF_7788, 2, "w2_rd14");

        // Illegal accesses leave memory untouched
        err_xfer(1, 32'h12, 4'd2, "err_unaligned");
        rd_ok(1, 32'h10, 32'hA522_3344, 2, "err_rd10");
        err_xfer(1, 32'h0000_1000, 4'd2, "err_range");
        rd_ok(1, 32'h0, 32'hCAFE_F00D, 2, "err_rd0");
        err_xfer(1, 32'h15, 4'd1, "err_half_odd");
        err_xfer(1, 32'h14, 4'd3, "err_size");
        rd_ok(1, 32'h14, 32'hBEEF_7788, 2, "err_rd14");

        // IDLE and BUSY with hsel high
        @(negedge clk);
        hsel[1] = 1'b1; hwrite[1] = 1'b1; haddr[1] = 32'h0;
        hsize[1] = 4'd2; hwdata[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            htrans[1] = (i < 2) ? 2'd0 : 2'd1;
            @(negedge clk);
            chk("idlebusy_hready", {31'd0, hready[1]}, 32'd1);
            chk("idlebusy_hresp", {31'd0, hresp[1]}, 32'd0);
        end
        idle_bus(1);
        rd_ok(1, 32'h0, 32'hCAFE_F00D, 2, "idlebusy_rd0");

        // Reset in the middle of a stalled write
        wr_ok(1, 32'h20, 4'd2, 32'h0BAD_F00D, 2, "rst_old_wr");
        rd_ok(1, 32'h20, 32'h0BAD_F00D, 2, "rst_old_rd");
        @(negedge clk);
        hsel[1] = 1'b1; htrans[1] = 2'd2; hwrite[1] = 1'b1;
        haddr[1] = 32'h20; hsize[1] = 4'd2;
        @(negedge clk);
        idle_bus(1);
        hwdata[1] = 32'h1234_5678;
        chk("rst_in_wait", {31'd0, hready[1]}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_hready", {31'd0, hready[1]}, 32'd1);
        chk("rst_async_hresp", {31'd0, hresp[1]}, 32'd0);
        chk("rst_async_hrdata", hrdata[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_ok(1, 32'h20, 32'h0BAD_F00D, 2, "rst_rd20");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
